// File: rtl/bitstream_loader_pkg.sv
// rtl/bitstream_loader_pkg.sv - shared constants, FSM state type and CRC-32 step for the flash loader
package bitstream_loader_pkg;

    localparam logic [7:0]  SPI_CMD_READ = 8'h03;
    localparam logic [31:0] CRC32_POLY   = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_CRC,
        ST_FINISH
    } loader_state_e;

    // Non-reflected CRC-32 over one 32-bit word, MSB first.
    function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic [31:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 31; i >= 0; i--) begin
            if (c[31] ^ data[i]) begin
                c = (c << 1) ^ CRC32_POLY;
            end else begin
                c = c << 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/spi_flash_phy.sv
// rtl/spi_flash_phy.sv - SPI mode-0 shifter: SCK divider, MSB-first tx/rx shift registers, bit counter
module spi_flash_phy #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [5:0]  len_i,
    input  logic [31:0] tx_data_i,
    output logic        ack_o,
    output logic        rx_done_o,
    output logic [31:0] rx_word_o,
    output logic        spi_sck_o,
    output logic        spi_mosi_o,
    input  logic        spi_miso_i
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

    logic          active_q;
    logic          sck_q;
    logic [DW-1:0] div_q;
    logic [5:0]    bit_q;
    logic [31:0]   tx_q;
    logic [31:0]   rx_q;

    logic tick;
    logic rise;
    logic fall;
    logic last;
    logic load;

    assign tick = active_q && (div_q == DIV_MAX);
    assign rise = tick && !sck_q;
    assign fall = tick && sck_q;
    assign last = (bit_q == 6'd1);

    assign ack_o     = fall && last;
    assign rx_done_o = rise && last;
    assign rx_word_o = {rx_q[30:0], spi_miso_i};

    // A new request accepted on the final falling edge chains seamlessly, keeping every SCK level CLK_DIV long.
    assign load = req_i && (!active_q || ack_o);

    assign spi_sck_o  = sck_q;
    assign spi_mosi_o = active_q & tx_q[31];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            active_q <= 1'b0;
            sck_q    <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
        end else if (load) begin
            active_q <= 1'b1;
            sck_q    <= 1'b0;
            div_q    <= '0;
            bit_q    <= len_i;
            tx_q     <= tx_data_i;
        end else if (active_q) begin
            if (tick) begin
                div_q <= '0;
                sck_q <= ~sck_q;
            end else begin
                div_q <= div_q + 1'b1;
            end
            if (rise) begin
                rx_q <= rx_word_o;
            end
            if (fall) begin
                if (last) begin
                    active_q <= 1'b0;
                end else begin
                    bit_q <= bit_q - 6'd1;
                    tx_q  <= {tx_q[30:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: rtl/bitstream_flash_loader.sv
// rtl/bitstream_flash_loader.sv - boot loader streaming a bitstream from SPI NOR flash; optional CRC via BITSTREAM_CRC_EN
module bitstream_flash_loader
    import bitstream_loader_pkg::*;
#(
    parameter logic [23:0] FLASH_ADDR = 24'h000000,
    parameter int unsigned NUM_WORDS  = 1024,
    parameter int unsigned CLK_DIV    = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        spi_sck_o,
    output logic        spi_cs_no,
    output logic        spi_mosi_o,
    input  logic        spi_miso_i,
    output logic [31:0] bitstream_data_o,
    output logic        bitstream_valid_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o
);

    localparam int unsigned WCW = $clog2(NUM_WORDS + 1);
    localparam int unsigned FW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [WCW-1:0] LAST_COUNT = WCW'(NUM_WORDS);
    localparam logic [FW-1:0]  FIN_MAX    = FW'(CLK_DIV - 1);

    loader_state_e  state_q, state_d;
    logic           cs_n_q, cs_n_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           valid_q, valid_d;
    logic [31:0]    data_q, data_d;
    logic [WCW-1:0] word_q, word_d;
    logic [FW-1:0]  fin_q, fin_d;
`ifdef BITSTREAM_CRC_EN
    logic           error_q, error_d;
    logic [31:0]    crc_q, crc_d;
`endif

    logic        phy_req;
    logic [5:0]  phy_len;
    logic [31:0] phy_tx;
    logic        phy_ack;
    logic        phy_rx_done;
    logic [31:0] phy_rx_word;

    spi_flash_phy #(
        .CLK_DIV (CLK_DIV)
    ) u_phy (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (phy_req),
        .len_i      (phy_len),
        .tx_data_i  (phy_tx),
        .ack_o      (phy_ack),
        .rx_done_o  (phy_rx_done),
        .rx_word_o  (phy_rx_word),
        .spi_sck_o  (spi_sck_o),
        .spi_mosi_o (spi_mosi_o),
        .spi_miso_i (spi_miso_i)
    );

    always_comb begin
        state_d = state_q;
        cs_n_d  = cs_n_q;
        busy_d  = busy_q;
        done_d  = done_q;
        valid_d = 1'b0;
        data_d  = data_q;
        word_d  = word_q;
        fin_d   = fin_q;
`ifdef BITSTREAM_CRC_EN
        error_d = error_q;
        crc_d   = crc_q;
`endif
        phy_req = 1'b0;
        phy_len = 6'd32;
        phy_tx  = 32'h0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    cs_n_d  = 1'b0;
                    word_d  = '0;
`ifdef BITSTREAM_CRC_EN
                    error_d = 1'b0;
                    crc_d   = CRC32_INIT;
`endif
                    phy_req = 1'b1;
                    phy_len = 6'd8;
                    phy_tx  = {SPI_CMD_READ, 24'h0};
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (phy_ack) begin
                    phy_req = 1'b1;
                    phy_len = 6'd24;
                    phy_tx  = {FLASH_ADDR, 8'h0};
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (phy_ack) begin
                    phy_req = 1'b1;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (phy_rx_done) begin
                    data_d  = phy_rx_word;
                    valid_d = 1'b1;
                    word_d  = word_q + 1'b1;
`ifdef BITSTREAM_CRC_EN
                    crc_d   = crc32_step(crc_q, phy_rx_word);
`endif
                end
                // word_q already counts the word whose last bit is ending here.
                if (phy_ack) begin
                    if (word_q == LAST_COUNT) begin
`ifdef BITSTREAM_CRC_EN
                        phy_req = 1'b1;
                        state_d = ST_CRC;
`else
                        cs_n_d  = 1'b1;
                        fin_d   = '0;
                        state_d = ST_FINISH;
`endif
                    end else begin
                        phy_req = 1'b1;
                    end
                end
            end
`ifdef BITSTREAM_CRC_EN
            ST_CRC: begin
                if (phy_rx_done) begin
                    error_d = (phy_rx_word != ~crc_q);
                end
                if (phy_ack) begin
                    cs_n_d  = 1'b1;
                    fin_d   = '0;
                    state_d = ST_FINISH;
                end
            end
`endif
            ST_FINISH: begin
                if (fin_q == FIN_MAX) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    fin_d = fin_q + 1'b1;
                end
            end
            default: begin
                cs_n_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            word_q  <= '0;
            fin_q   <= '0;
`ifdef BITSTREAM_CRC_EN
            error_q <= 1'b0;
            crc_q   <= CRC32_INIT;
`endif
        end else begin
            state_q <= state_d;
            cs_n_q  <= cs_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            word_q  <= word_d;
            fin_q   <= fin_d;
`ifdef BITSTREAM_CRC_EN
            error_q <= error_d;
            crc_q   <= crc_d;
`endif
        end
    end

    assign spi_cs_no         = cs_n_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign bitstream_valid_o = valid_q;
    assign bitstream_data_o  = data_q;
`ifdef BITSTREAM_CRC_EN
    assign error_o = error_q;
`else
    assign error_o = 1'b0;
`endif

endmodule
